conv_result_bram_writer: RTL and testbench
==========================================

CONV_RESULT_BRAM_WRITER -- requirements
Module: conv_result_bram_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning result byte width.
REQ-002 SHALL have parameter WORD_W, default 64, meaning BRAM word width (WORD_W/DATA_W = 8 lanes).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning BRAM word address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle job start request.
REQ-007 SHALL have port base_addr  input  ADDR_W  first word address of the job.
REQ-008 SHALL have port num_bytes  input  16  result bytes in the job.
REQ-009 SHALL have port in_valid  input  1  result byte valid.
REQ-010 SHALL have port in_data  input  DATA_W  result byte.
REQ-011 SHALL have port in_ready  output  1  writer accepts a byte this cycle.
REQ-012 SHALL have port ena  output  1  BRAM port enable.
REQ-013 SHALL have port wea  output  1  BRAM write enable.
REQ-014 SHALL have port addra  output  ADDR_W  BRAM word address.
REQ-015 SHALL have port dina  output  WORD_W  BRAM write data.
REQ-016 SHALL have port busy  output  1  job in progress.
REQ-017 SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-018 SHALL implement states IDLE, PACK, DONE; busy = 1 in PACK and DONE.
REQ-019 In IDLE, start SHALL latch base_addr and num_bytes; num_bytes != 0 -> PACK, num_bytes == 0 -> DONE with no BRAM write.
REQ-020 start SHALL be ignored while busy.
REQ-021 in_ready SHALL be 1 exactly in PACK while accepted bytes < num_bytes; a byte is accepted on in_valid & in_ready.
REQ-022 Accepted byte k of a word SHALL land in lane k, bits [8k+7:8k]; lane 0 filled first.
REQ-023 On accepting lane 7 or the job's last byte, the word SHALL be written one cycle later: ena = wea = 1 for exactly one cycle, addra = current word address, dina = packed word, unfilled lanes zero.
REQ-024 Packing SHALL continue without stall during that write cycle: back-to-back bytes at full rate, no dropped or duplicated bytes.
REQ-025 Word address SHALL start at base_addr, increment by 1 per write, and wrap modulo 2^ADDR_W.
REQ-026 After the last write is issued, the FSM SHALL enter DONE; done SHALL pulse for one cycle in DONE, then return to IDLE.
REQ-027 ena, wea, addra, dina SHALL all be registered outputs; ena = wea = 0 and dina held otherwise.

Reset
REQ-028 rst SHALL asynchronously force IDLE, in_ready = ena = wea = busy = done = 0, addra = 0, dina = 0, counters and pack register cleared.
REQ-029 rst mid-job SHALL abandon the partial word with no further BRAM write; the next start begins a fresh job.

Structure
REQ-030 State encoding and lane count constant (WORD_W/DATA_W) SHALL live in a shared package conv_pkg.
REQ-031 A sub-module byte_packer (lane counter, pack register, word-complete flag) is natural; the FSM and address counter SHALL remain in the top.

Verification
REQ-032 base_addr=0x010, num_bytes=16, bytes 0x00..0x0F at full rate -> writes addr 0x010 dina 0x0706050403020100, addr 0x011 dina 0x0F0E0D0C0B0A0908, then done pulse.
REQ-033 num_bytes=11, bytes 0xA0..0xAA -> second write dina 0x0000000000AAA9A8, then done.
REQ-034 base_addr=0xFFF, num_bytes=16 -> writes at 0xFFF then 0x000.
REQ-035 num_bytes=0 -> no ena/wea, done pulses within two cycles of start; start asserted while busy -> ignored, job unchanged.
REQ-036 in_valid toggling 1/0 every cycle, num_bytes=8 -> one write with all 8 bytes in order; rst asserted after 5 bytes -> no write, outputs zero immediately.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution result BRAM writer.
//   DEF_DATA_W / DEF_WORD_W : default byte and BRAM word widths
//   NUM_LANES               : bytes packed into one BRAM word
//   LANE_W                  : width of a lane index
//   state_t                 : writer FSM states
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_WORD_W = 64;
    localparam int NUM_LANES  = DEF_WORD_W / DEF_DATA_W;
    localparam int LANE_W     = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Collects result bytes into one BRAM word, lane 0 first.
//   clk, rst     : clock, asynchronous active-high reset
//   i_clear      : drop any partial word and restart at lane 0
//   i_accept     : a byte is accepted this cycle
//   i_last       : the accepted byte is the last one of the job
//   i_data       : the byte being accepted
//   o_word       : pack register with the current byte merged in
//   o_wordDone   : word complete this cycle (lane 7 filled or last byte)
// ---------------------------------------------------------------------------
module byte_packer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORD_W = DEF_WORD_W
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_data,
    output logic [WORD_W-1:0] o_word,
    output logic              o_wordDone
);

    logic [LANE_W-1:0] r_lane;
    logic [WORD_W-1:0] r_pack;
    logic [WORD_W-1:0] w_merged;

    // The merged word is handed out combinationally so the top can register
    // it into the BRAM data port on the same edge that accepts the final byte.
    always_comb begin
        w_merged = r_pack;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_lane == LANE_W'(i)) begin
                w_merged[i*DATA_W +: DATA_W] = i_data;
            end
        end
    end

    assign o_word     = w_merged;
    assign o_wordDone = i_accept && ((r_lane == LANE_W'(NUM_LANES - 1)) || i_last);

    // A completed word empties the pack register immediately, so unfilled
    // lanes of the next word are zero and packing never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= '0;
            r_pack <= '0;
        end else if (i_clear || o_wordDone) begin
            r_lane <= '0;
            r_pack <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + LANE_W'(1);
            r_pack <= w_merged;
        end
    end

endmodule

// File: rtl/conv_result_bram_writer.sv
// ---------------------------------------------------------------------------
// conv_result_bram_writer
// Packs a stream of convolution result bytes into wide BRAM words and writes
// them to consecutive word addresses starting at a job base address.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : one-cycle job request (ignored while busy)
//   base_addr          : first BRAM word address of the job
//   num_bytes          : result bytes in the job (0 = empty job)
//   in_valid, in_data  : result byte stream
//   in_ready           : byte accepted when in_valid & in_ready
//   ena, wea           : registered BRAM enable / write enable
//   addra, dina        : registered BRAM word address / write data
//   busy               : job in progress
//   done               : one-cycle job-complete pulse
// ---------------------------------------------------------------------------
module conv_result_bram_writer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int WORD_W = DEF_WORD_W,
    parameter int ADDR_W = 12
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_bytes,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [WORD_W-1:0] dina,
    output logic              busy,
    output logic              done
);

    state_t            r_state;
    state_t            w_nextState;
    logic [15:0]       r_num;
    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addra;
    logic [WORD_W-1:0] r_dina;
    logic              r_ena;

    logic              w_jobStart;
    logic              w_inReady;
    logic              w_accept;
    logic              w_last;
    logic              w_wordDone;
    logic [WORD_W-1:0] w_word;

    assign w_jobStart = (r_state == ST_IDLE) && start;
    assign w_inReady  = (r_state == ST_PACK) && (r_count < r_num);
    assign w_accept   = in_valid && w_inReady;
    assign w_last     = ((r_count + 16'd1) == r_num);

    byte_packer #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_jobStart),
        .i_accept   (w_accept),
        .i_last     (w_last),
        .i_data     (in_data),
        .o_word     (w_word),
        .o_wordDone (w_wordDone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // PACK only leaves once every byte has been taken and the final word is
    // actually on the BRAM port, so done always follows the last write.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = (num_bytes != 16'd0) ? ST_PACK : ST_DONE;
                end
            end
            ST_PACK: begin
                if (r_ena && (r_count == r_num)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Job bookkeeping and the registered BRAM port. A word is issued on the
    // edge that accepts its final byte, so it appears one cycle later while
    // the next byte is already being packed. The address wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num   <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_addra <= '0;
            r_dina  <= '0;
            r_ena   <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            if (w_jobStart) begin
                r_num   <= num_bytes;
                r_count <= '0;
                r_addr  <= base_addr;
            end
            if (w_accept) begin
                r_count <= r_count + 16'd1;
            end
            if (w_wordDone) begin
                r_ena   <= 1'b1;
                r_addra <= r_addr;
                r_dina  <= w_word;
                r_addr  <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign in_ready = w_inReady;
    assign ena      = r_ena;
    assign wea      = r_ena;
    assign addra    = r_addra;
    assign dina     = r_dina;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_conv_result_bram_writer.sv
// ---------------------------------------------------------------------------
// tb_conv_result_bram_writer
// Self-checking bench for conv_result_bram_writer: a table of directed jobs,
// hand-written sequences for empty jobs and mid-job reset, and random jobs,
// all compared against a word-level reference built from the byte list.
// ---------------------------------------------------------------------------
module tb_conv_result_bram_writer;

    localparam int DATA_W = 8;
    localparam int WORD_W = 64;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       num_bytes;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [WORD_W-1:0] dina;
    logic              busy;
    logic              done;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                num;
        logic [7:0]        first;
        int                mode;
        bit                poke;
        int                expWrites;
        logic [ADDR_W-1:0] expLastAddr;
        logic [WORD_W-1:0] expLastData;
    } vec_t;

    int         assertCount = 0;
    int         failCount   = 0;
    int         doneCnt     = 0;
    wr_t        capQ[$];
    wr_t        expQ[$];
    logic [7:0] jobBytes [0:255];
    vec_t       vecs [7];

    conv_result_bram_writer #(
        .DATA_W (DATA_W),
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_bytes (num_bytes),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Port monitor: every BRAM write and every cycle of done is recorded.
    always @(negedge clk) begin
        if (ena) capQ.push_back('{addr: addra, data: dina});
        if (done) doneCnt++;
        if (ena || wea) checkOutput("wea_tracks_ena", 64'(wea), 64'(ena));
    end

    // Reference: word w holds bytes 8w..8w+7 little-end first, zero padded,
    // at address base+w modulo the address space.
    task automatic buildExpected(input logic [ADDR_W-1:0] base, input int n);
        wr_t e;
        expQ.delete();
        for (int w = 0; w * 8 < n; w++) begin
            e.addr = ADDR_W'((int'(base) + w) % (1 << ADDR_W));
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                if (w * 8 + k < n) e.data[k*8 +: 8] = jobBytes[w*8 + k];
            end
            expQ.push_back(e);
        end
    endtask

    task automatic verifyJob(input string name);
        checkOutput({name, "_write_count"}, 64'(capQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", name, i), 64'(capQ[i].addr), 64'(expQ[i].addr));
            checkOutput($sformatf("%s_data%0d", name, i), capQ[i].data, expQ[i].data);
        end
        checkOutput({name, "_done_pulses"}, 64'(doneCnt), 64'd1);
        checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    // mode 0: full rate, 1: valid toggles every cycle, 2: random valid.
    // poke raises start with a different job while this one is running.
    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int n, input int mode, input bit poke);
        int  idx;
        int  cycles;
        bit  poked;
        capQ.delete();
        doneCnt = 0;
        poked   = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        num_bytes = 16'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        num_bytes = 16'($urandom);
        idx    = 0;
        cycles = 0;
        while (idx < n && cycles < 2000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cycles % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = jobBytes[idx];
            if (poke && !poked && idx == 3) begin
                start     = 1'b1;
                base_addr = 12'h555;
                num_bytes = 16'd3;
                poked     = 1'b1;
            end else begin
                start = 1'b0;
            end
            #3;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        checkOutput("bytes_accepted", 64'(idx), 64'(n));
        cycles = 0;
        while (doneCnt == 0 && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int idx;
        int cycles;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_bytes = '0;
        in_valid  = 1'b0;
        in_data   = '0;

        vecs[0] = '{12'h010, 16, 8'h00, 0, 1'b0, 2, 12'h011, 64'h0F0E0D0C0B0A0908};
        vecs[1] = '{12'h020, 11, 8'hA0, 0, 1'b0, 2, 12'h021, 64'h0000000000AAA9A8};
        vecs[2] = '{12'hFFF, 16, 8'h30, 0, 1'b0, 2, 12'h000, 64'h3F3E3D3C3B3A3938};
        vecs[3] = '{12'h100,  8, 8'h51, 1, 1'b0, 1, 12'h100, 64'h5857565554535251};
        vecs[4] = '{12'h200,  0, 8'h00, 0, 1'b0, 0, 12'h000, 64'h0};
        vecs[5] = '{12'h7FE, 20, 8'h10, 2, 1'b0, 3, 12'h800, 64'h0000000023222120};
        vecs[6] = '{12'h300,  8, 8'hC0, 0, 1'b1, 1, 12'h300, 64'hC7C6C5C4C3C2C1C0};

        #23;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_ena", 64'(ena), 64'd0);
        checkOutput("reset_wea", 64'(wea), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_addra", 64'(addra), 64'd0);
        checkOutput("reset_dina", dina, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].num; i++) jobBytes[i] = vecs[v].first + 8'(i);
            applyStimulus(vecs[v].base, vecs[v].num, vecs[v].mode, vecs[v].poke);
            buildExpected(vecs[v].base, vecs[v].num);
            verifyJob($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_table_writes", v), 64'(capQ.size()), 64'(vecs[v].expWrites));
            if (vecs[v].expWrites > 0 && capQ.size() > 0) begin
                checkOutput($sformatf("vec%0d_table_last_addr", v), 64'(capQ[capQ.size()-1].addr), 64'(vecs[v].expLastAddr));
                checkOutput($sformatf("vec%0d_table_last_data", v), capQ[capQ.size()-1].data, vecs[v].expLastData);
            end
        end

        // Empty job: done in the cycle right after the start edge, no write.
        capQ.delete();
        doneCnt = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 12'h123;
        num_bytes = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("zero_done_next_cycle", 64'(done), 64'd1);
        checkOutput("zero_busy_next_cycle", 64'(busy), 64'd1);
        @(posedge clk); #1;
        checkOutput("zero_done_cleared", 64'(done), 64'd0);
        checkOutput("zero_busy_cleared", 64'(busy), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("zero_no_write", 64'(capQ.size()), 64'd0);
        checkOutput("zero_done_pulses", 64'(doneCnt), 64'd1);

        // Reset after five of eight bytes: partial word must vanish.
        for (int i = 0; i < 8; i++) jobBytes[i] = 8'h61 + 8'(i);
        capQ.delete();
        doneCnt = 0;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = 12'h400;
        num_bytes = 16'd8;
        @(posedge clk); #1;
        start  = 1'b0;
        idx    = 0;
        cycles = 0;
        while (idx < 5 && cycles < 100) begin
            in_valid = (cycles % 2 == 0);
            in_data  = jobBytes[idx];
            #3;
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("rst_job_bytes_before_reset", 64'(idx), 64'd5);
        rst = 1'b1;
        #1;
        checkOutput("rst_job_ena", 64'(ena), 64'd0);
        checkOutput("rst_job_wea", 64'(wea), 64'd0);
        checkOutput("rst_job_addra", 64'(addra), 64'd0);
        checkOutput("rst_job_dina", dina, 64'd0);
        checkOutput("rst_job_busy", 64'(busy), 64'd0);
        checkOutput("rst_job_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_job_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_job_no_write", 64'(capQ.size()), 64'd0);
        checkOutput("rst_job_no_done", 64'(doneCnt), 64'd0);

        for (int i = 0; i < 3; i++) jobBytes[i] = 8'h71 + 8'(i);
        applyStimulus(12'h410, 3, 0, 1'b0);
        buildExpected(12'h410, 3);
        verifyJob("fresh_after_reset");

        // Random jobs.
        for (int r = 0; r < 8; r++) begin
            logic [ADDR_W-1:0] rb;
            int                rn;
            rb = ADDR_W'($urandom);
            rn = $urandom_range(0, 40);
            for (int i = 0; i < rn; i++) jobBytes[i] = 8'($urandom);
            applyStimulus(rb, rn, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            buildExpected(rb, rn);
            verifyJob($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
